// File: rtl/cmp_flag_stats_pkg.sv
// Shared types for the comparator flag statistics block: FSM states and the
// 2-bit class encoding reported on last_class.
package cmp_flag_stats_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic [1:0] CLS_NONE = 2'b00;
  localparam logic [1:0] CLS_LT   = 2'b01;
  localparam logic [1:0] CLS_EQ   = 2'b10;
  localparam logic [1:0] CLS_GT   = 2'b11;

  // Flags are ordered {lt, eq, gt}; only meaningful for one-hot inputs.
  function automatic logic [1:0] flags_to_cls(input logic [2:0] f);
    logic [1:0] c;
    c = CLS_NONE;
    case (f)
      3'b100:  c = CLS_LT;
      3'b010:  c = CLS_EQ;
      3'b001:  c = CLS_GT;
      default: c = CLS_NONE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/cmp_flag_stats_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      q <= '0;
    else if (clr)                    q <= '0;
    else if (inc && (q != {W{1'b1}})) q <= q + 1'b1;
  end

endmodule

// File: rtl/cmp_flag_stats.sv
// Windowed statistics over comparator flags with start/busy/done handshake.
// Optional transition counter enabled by defining CMP_STATS_TRANSITION_EN.
module cmp_flag_stats
  import cmp_flag_stats_pkg::*;
#(
  parameter int CNT_W   = 8,
  parameter int WIN_LEN = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  input  logic             a_less_b,
  input  logic             a_equal_b,
  input  logic             a_greater_b,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] lt_count,
  output logic [CNT_W-1:0] eq_count,
  output logic [CNT_W-1:0] gt_count,
  output logic             err_flag,
  output logic [1:0]       last_class
`ifdef CMP_STATS_TRANSITION_EN
  ,
  output logic [CNT_W-1:0] chg_count
`endif
);

  localparam int SCNT_W = $clog2(WIN_LEN + 1);
  localparam logic [SCNT_W-1:0] LAST_IDX = SCNT_W'(WIN_LEN - 1);

  state_e            state, state_nxt;
  logic [SCNT_W-1:0] scnt;
  logic [2:0]        flags;
  logic              take_start, accept, legal, last_hit;
  logic [1:0]        cls;
  logic [2:0]        cnt_inc;
  logic [2:0][CNT_W-1:0] cnt_q;

  assign flags      = {a_less_b, a_equal_b, a_greater_b};
  assign take_start = (state == IDLE) && start;
  assign accept     = (state == COUNT) && in_valid;
  assign legal      = $onehot(flags);
  assign cls        = flags_to_cls(flags);
  // Window ends on the sample that brings the accepted count to WIN_LEN.
  assign last_hit   = accept && (scnt == LAST_IDX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE:    if (start) state_nxt = COUNT;
      COUNT: begin
        busy = 1'b1;
        if (last_hit) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scnt       <= '0;
      err_flag   <= 1'b0;
      last_class <= CLS_NONE;
    end else if (take_start) begin
      scnt       <= '0;
      err_flag   <= 1'b0;
      last_class <= CLS_NONE;
    end else if (accept) begin
      scnt <= scnt + 1'b1;
      if (legal) last_class <= cls;
      else       err_flag   <= 1'b1;
    end
  end

  // Counter index 2/1/0 = lt/eq/gt, matching the flag vector order.
  for (genvar i = 0; i < 3; i++) begin : g_cnt
    assign cnt_inc[i] = accept && legal && flags[i];
    sat_counter #(.W(CNT_W)) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (take_start),
      .inc   (cnt_inc[i]),
      .q     (cnt_q[i])
    );
  end

  assign lt_count = cnt_q[2];
  assign eq_count = cnt_q[1];
  assign gt_count = cnt_q[0];

`ifdef CMP_STATS_TRANSITION_EN
  logic chg_inc;
  // last_class is CLS_NONE until the first legal sample, so that one never counts.
  assign chg_inc = accept && legal && (last_class != CLS_NONE) && (cls != last_class);

  sat_counter #(.W(CNT_W)) u_chg (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (take_start),
    .inc   (chg_inc),
    .q     (chg_count)
  );
`endif

endmodule

// File: tb/tb_cmp_flag_stats.sv
// Randomized and directed windows checked against a queue-based window model.
module tb_cmp_flag_stats;

  localparam int CNT_W   = 3;
  localparam int WIN_LEN = 12;
  localparam int MAXC    = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst_n, start, in_valid, a_less_b, a_equal_b, a_greater_b;
  logic busy, done, err_flag;
  logic [CNT_W-1:0] lt_count, eq_count, gt_count;
  logic [1:0] last_class;
`ifdef CMP_STATS_TRANSITION_EN
  logic [CNT_W-1:0] chg_count;
`endif

  int checks = 0;
  int errors = 0;
  logic [2:0] win_q[$];

  always #5 clk = ~clk;

  cmp_flag_stats #(.CNT_W(CNT_W), .WIN_LEN(WIN_LEN)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .in_valid    (in_valid),
    .a_less_b    (a_less_b),
    .a_equal_b   (a_equal_b),
    .a_greater_b (a_greater_b),
    .busy        (busy),
    .done        (done),
    .lt_count    (lt_count),
    .eq_count    (eq_count),
    .gt_count    (gt_count),
    .err_flag    (err_flag),
    .last_class  (last_class)
`ifdef CMP_STATS_TRANSITION_EN
    ,
    .chg_count   (chg_count)
`endif
  );

  function automatic int sat(input int n);
    return (n > MAXC) ? MAXC : n;
  endfunction

  function automatic int n_of(input logic [2:0] f);
    int n = 0;
    foreach (win_q[i]) if (win_q[i] == f) n++;
    return n;
  endfunction

  function automatic int cls_of(input logic [2:0] f);
    if (f == 3'b100) return 1;
    if (f == 3'b010) return 2;
    if (f == 3'b001) return 3;
    return 0;
  endfunction

  function automatic int exp_err();
    foreach (win_q[i]) if (cls_of(win_q[i]) == 0) return 1;
    return 0;
  endfunction

  function automatic int exp_last();
    int c = 0;
    foreach (win_q[i]) if (cls_of(win_q[i]) != 0) c = cls_of(win_q[i]);
    return c;
  endfunction

  function automatic int exp_chg();
    int prev = 0;
    int n = 0;
    foreach (win_q[i]) begin
      int c = cls_of(win_q[i]);
      if (c != 0) begin
        if (prev != 0 && c != prev) n++;
        prev = c;
      end
    end
    return sat(n);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_stats(input string tag);
    chk({tag, ".lt"},   32'(lt_count),   32'(sat(n_of(3'b100))));
    chk({tag, ".eq"},   32'(eq_count),   32'(sat(n_of(3'b010))));
    chk({tag, ".gt"},   32'(gt_count),   32'(sat(n_of(3'b001))));
    chk({tag, ".err"},  32'(err_flag),   32'(exp_err()));
    chk({tag, ".last"}, 32'(last_class), 32'(exp_last()));
`ifdef CMP_STATS_TRANSITION_EN
    chk({tag, ".chg"},  32'(chg_count),  32'(exp_chg()));
`endif
  endtask

  task automatic drive_flags(input logic [2:0] f);
    {a_less_b, a_equal_b, a_greater_b} = f;
  endtask

  // mode 0 random, 1 mixed 4/4/4, 2 gapped eq, 3 illegal mix, 4 all lt, 5 transitions
  task automatic run_window(input int mode, input string tag);
    int k = 0;
    logic v;
    logic [2:0] f;
    logic [2:0] ill [4];
    logic [2:0] trn [6];
    ill = '{3'b000, 3'b110, 3'b100, 3'b001};
    trn = '{3'b100, 3'b100, 3'b010, 3'b001, 3'b001, 3'b100};
    start = 1'b1;
    in_valid = 1'($urandom_range(0, 1));
    drive_flags(3'($urandom));
    @(posedge clk); #1;
    start = 1'b0;
    win_q.delete();
    chk({tag, ".start_busy"}, 32'(busy), 32'd1);
    check_stats({tag, ".clr"});
    while (win_q.size() < WIN_LEN && k < 200) begin
      case (mode)
        1: begin
          v = 1'b1;
          f = (win_q.size() < 4) ? 3'b100 : (win_q.size() < 8) ? 3'b010 : 3'b001;
        end
        2: begin v = (k % 2 == 0); f = v ? 3'b010 : 3'($urandom); end
        3: begin v = 1'b1; f = ill[win_q.size() % 4]; end
        4: begin v = 1'b1; f = 3'b100; end
        5: begin v = 1'b1; f = trn[win_q.size() % 6]; end
        default: begin
          v = ($urandom_range(0, 2) != 0);
          f = ($urandom_range(0, 3) != 0) ? (3'b100 >> $urandom_range(0, 2)) : 3'($urandom);
        end
      endcase
      in_valid = v;
      drive_flags(f);
      start = (mode == 0) ? ($urandom_range(0, 3) == 0) : 1'b0;
      @(posedge clk); #1;
      k++;
      if (v) win_q.push_back(f);
      if (win_q.size() < WIN_LEN) begin
        chk({tag, ".busy"}, 32'(busy), 32'd1);
        chk({tag, ".early_done"}, 32'(done), 32'd0);
      end
      check_stats({tag, ".run"});
    end
    if (k >= 200) begin
      errors++;
      $error("FAIL %s.timeout observed=%0d expected=%0d", tag, win_q.size(), WIN_LEN);
    end
    start = 1'b0;
    chk({tag, ".done"}, 32'(done), 32'd1);
    chk({tag, ".done_busy"}, 32'(busy), 32'd0);
    in_valid = 1'b1;
    drive_flags(3'b100);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk({tag, ".done_pulse"}, 32'(done), 32'd0);
    chk({tag, ".idle_busy"}, 32'(busy), 32'd0);
    check_stats({tag, ".hold"});
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    in_valid = 1'b0;
    drive_flags(3'b000);
    win_q.delete();
    repeat (3) @(posedge clk);
    #1;
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.done", 32'(done), 32'd0);
    check_stats("rst");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // valid in IDLE must be ignored
    in_valid = 1'b1;
    drive_flags(3'b010);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("idle.busy", 32'(busy), 32'd0);
    check_stats("idle");

    run_window(1, "mixed");
    run_window(2, "gapped");
    run_window(3, "illegal");
    run_window(4, "sat");
    run_window(5, "trans");
    for (int i = 0; i < 6; i++) run_window(0, "rand");

    // reset in the middle of a window
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    in_valid = 1'b1;
    drive_flags(3'b100);
    repeat (3) begin @(posedge clk); #1; end
    chk("abort.pre_lt", 32'(lt_count), 32'd3);
    rst_n = 1'b0;
    #2;
    win_q.delete();
    chk("abort.busy", 32'(busy), 32'd0);
    chk("abort.done", 32'(done), 32'd0);
    check_stats("abort");
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (WIN_LEN) begin
      @(posedge clk); #1;
      chk("abort.no_done", 32'(done), 32'd0);
      chk("abort.idle", 32'(busy), 32'd0);
    end
    in_valid = 1'b0;
    check_stats("abort.after");

    run_window(0, "post");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
